// File: rtl/fcs_gen_serial_if.sv
// Serial FCS generator handshake bundle: bit-wide input with valid/ready, registered output stream.
// master drives payload bits and consumes the stream; slave is the generator itself.
interface fcs_gen_serial_if;
   logic in_valid;
   logic in_ready;
   logic start_of_frame;
   logic end_of_frame;
   logic data_in;
   logic out_valid;
   logic data_out;
   logic out_sof;
   logic out_fcs_start;
   logic out_last;

   modport master (
      output in_valid, start_of_frame, end_of_frame, data_in,
      input  in_ready, out_valid, data_out, out_sof, out_fcs_start, out_last
   );

   modport slave (
      input  in_valid, start_of_frame, end_of_frame, data_in,
      output in_ready, out_valid, data_out, out_sof, out_fcs_start, out_last
   );
endinterface

// File: rtl/fcs_gen_serial.sv
// Serial Ethernet FCS generator: echoes payload, zero-pads to MIN_BITS, appends ~CRC32 MSB first.
// Latency 1 cycle (all outputs registered); in_ready drops for the whole pad+FCS tail, no output stall.
module fcs_gen_serial #(
   parameter logic [31:0] POLY     = 32'h04C11DB7,
   parameter logic [31:0] INIT     = 32'hFFFFFFFF,
   parameter int unsigned MIN_BITS = 480
) (
   input  logic            clk,
   input  logic            reset,
   fcs_gen_serial_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD, S_FCS} state_t;

   localparam logic [16:0] MIN_L    = 17'(MIN_BITS);
   // Unreachable when MIN_BITS is 0: the PAD state is never entered then.
   localparam logic [15:0] PAD_LAST = 16'(MIN_BITS - 1);

   state_t      state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic [15:0] cnt_q, cnt_d;
   logic [4:0]  idx_q, idx_d;
   logic        out_valid_q, out_valid_d;
   logic        data_out_q, data_out_d;
   logic        out_sof_q, out_sof_d;
   logic        out_fcs_start_q, out_fcs_start_d;
   logic        out_last_q, out_last_d;

   logic        in_ready;
   logic        accept;
   logic [15:0] cnt_inc;
   logic [15:0] cnt_nx;
   logic        pad_needed;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
      return {c[30:0], 1'b0} ^ ((b ^ c[31]) ? POLY : 32'd0);
   endfunction

   assign in_ready   = (state_q == S_IDLE) || (state_q == S_DATA);
   assign accept     = bus.in_valid && in_ready;
   assign cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign cnt_nx     = (state_q == S_IDLE) ? 16'd1 : cnt_inc;
   assign pad_needed = ({1'b0, cnt_nx} < MIN_L);

   always_comb begin
      state_d         = state_q;
      crc_d           = crc_q;
      cnt_d           = cnt_q;
      idx_d           = idx_q;
      out_valid_d     = 1'b0;
      data_out_d      = 1'b0;
      out_sof_d       = 1'b0;
      out_fcs_start_d = 1'b0;
      out_last_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept && bus.start_of_frame) begin
               crc_d       = crc_step(INIT, bus.data_in);
               cnt_d       = cnt_nx;
               idx_d       = 5'd0;
               out_valid_d = 1'b1;
               data_out_d  = bus.data_in;
               out_sof_d   = 1'b1;
               if (bus.end_of_frame) state_d = pad_needed ? S_PAD : S_FCS;
               else                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               crc_d       = crc_step(crc_q, bus.data_in);
               cnt_d       = cnt_nx;
               out_valid_d = 1'b1;
               data_out_d  = bus.data_in;
               if (bus.end_of_frame) state_d = pad_needed ? S_PAD : S_FCS;
            end
         end
         S_PAD: begin
            crc_d       = crc_step(crc_q, 1'b0);
            cnt_d       = cnt_inc;
            out_valid_d = 1'b1;
            if (cnt_q >= PAD_LAST) state_d = S_FCS;
         end
         S_FCS: begin
            // Complemented remainder leaves MSB first; idx wraps back to 0 for the next frame.
            out_valid_d     = 1'b1;
            data_out_d      = ~crc_q[31];
            crc_d           = {crc_q[30:0], 1'b0};
            out_fcs_start_d = (idx_q == 5'd0);
            out_last_d      = (idx_q == 5'd31);
            idx_d           = idx_q + 5'd1;
            if (idx_q == 5'd31) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         crc_q           <= INIT;
         cnt_q           <= 16'd0;
         idx_q           <= 5'd0;
         out_valid_q     <= 1'b0;
         data_out_q      <= 1'b0;
         out_sof_q       <= 1'b0;
         out_fcs_start_q <= 1'b0;
         out_last_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         crc_q           <= crc_d;
         cnt_q           <= cnt_d;
         idx_q           <= idx_d;
         out_valid_q     <= out_valid_d;
         data_out_q      <= data_out_d;
         out_sof_q       <= out_sof_d;
         out_fcs_start_q <= out_fcs_start_d;
         out_last_q      <= out_last_d;
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid_q;
   assign bus.data_out      = data_out_q;
   assign bus.out_sof       = out_sof_q;
   assign bus.out_fcs_start = out_fcs_start_q;
   assign bus.out_last      = out_last_q;
endmodule

// File: tb/tb_fcs_gen_serial.sv
// Bench for fcs_gen_serial: two instances (MIN_BITS=0 and 480) checked by a scoreboard
// fed from a reflected-CRC reference model and by a receive-side residue check on every frame.
module tb_fcs_gen_serial;
   typedef struct packed {
      logic d;
      logic sof;
      logic fs;
      logic last;
   } exp_t;
   typedef bit bitq_t[$];

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic drv_valid = 1'b0;
   logic drv_sof = 1'b0;
   logic drv_eof = 1'b0;
   logic drv_dat = 1'b0;
   int   drv_sel = 2;

   int checks = 0;
   int errors = 0;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] rc[2];
   logic [31:0] fw[2];
   int          pos[2];
   int          fsp[2];
   int          lsp[2];
   int          fk[2];

   fcs_gen_serial_if bus0();
   fcs_gen_serial_if bus1();

   assign bus0.in_valid       = drv_valid && (drv_sel != 1);
   assign bus0.start_of_frame = drv_sof;
   assign bus0.end_of_frame   = drv_eof;
   assign bus0.data_in        = drv_dat;
   assign bus1.in_valid       = drv_valid && (drv_sel != 0);
   assign bus1.start_of_frame = drv_sof;
   assign bus1.end_of_frame   = drv_eof;
   assign bus1.data_in        = drv_dat;

   fcs_gen_serial #(.MIN_BITS(0))   u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
   fcs_gen_serial #(.MIN_BITS(480)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Standard LSB-first (reflected) CRC-32 formulation.
   function automatic logic [31:0] rstep(input logic [31:0] c, input logic b);
      return (c >> 1) ^ ((c[0] ^ b) ? 32'hEDB88320 : 32'd0);
   endfunction

   function automatic logic rdy(input int d);
      return (d == 0) ? bus0.in_ready : bus1.in_ready;
   endfunction

   function automatic logic outv(input int d);
      return (d == 0) ? bus0.out_valid : bus1.out_valid;
   endfunction

   function automatic bitq_t rand_bits(input int n);
      bitq_t q;
      for (int i = 0; i < n; i++) q.push_back(bit'($urandom_range(1)));
      return q;
   endfunction

   task automatic push_exp(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic push_frame(input int d, input int minb, input bitq_t pl);
      bitq_t       s;
      logic [31:0] c;
      exp_t        e;
      s = pl;
      while (s.size() < minb) s.push_back(1'b0);
      c = 32'hFFFFFFFF;
      foreach (s[i]) c = rstep(c, s[i]);
      c = ~c;
      foreach (s[i]) begin
         e.d = s[i]; e.sof = (i == 0); e.fs = 1'b0; e.last = 1'b0;
         push_exp(d, e);
      end
      for (int k = 0; k < 32; k++) begin
         e.d = c[k]; e.sof = 1'b0; e.fs = (k == 0); e.last = (k == 31);
         push_exp(d, e);
      end
   endtask

   task automatic mon(input int d, input logic v, input logic dat, input logic sof,
                      input logic fs, input logic last);
      exp_t e;
      if (!v) begin
         chk("idle_flags", {sof, fs, last}, 3'b000);
         return;
      end
      if (sof) begin
         pos[d] = 1;
         rc[d]  = rstep(32'hFFFFFFFF, dat);
      end else begin
         pos[d]++;
         rc[d] = rstep(rc[d], dat);
      end
      if (fs) begin
         fsp[d] = pos[d];
         fk[d]  = 0;
      end
      if (fk[d] < 32) begin
         fw[d][fk[d]] = dat;
         fk[d]++;
      end
      if (last) begin
         lsp[d] = pos[d];
         chk("rx_residue", rc[d], 32'hDEBB20E3);
      end
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
         chk("unexpected_out", 1'b1, 1'b0);
      end else begin
         e = (d == 0) ? q0.pop_front() : q1.pop_front();
         chk("stream", {dat, sof, fs, last}, e);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         mon(0, bus0.out_valid, bus0.data_out, bus0.out_sof, bus0.out_fcs_start, bus0.out_last);
         mon(1, bus1.out_valid, bus1.data_out, bus1.out_sof, bus1.out_fcs_start, bus1.out_last);
      end
   end

   task automatic drive(input int d, input bitq_t pl, input int gap_pct);
      int   i = 0;
      int   n = 0;
      bit   started = 0;
      logic gap;
      logic acc;
      drv_sel = d;
      while (i < pl.size()) begin
         gap       = started && ($urandom_range(99) < gap_pct);
         drv_valid = !gap;
         drv_dat   = pl[i];
         drv_sof   = (i == 0);
         drv_eof   = (i == pl.size() - 1);
         acc       = !gap && rdy(d);
         @(posedge clk);
         #1;
         if (gap) chk("gap_out_valid", outv(d), 1'b0);
         if (acc) begin
            i++;
            started = 1;
         end
         n++;
         if (n > 5000) begin
            chk("drive_timeout", 1'b0, 1'b1);
            break;
         end
      end
      drv_valid = 1'b0;
      drv_sof   = 1'b0;
      drv_eof   = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int n = 0;
      while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain", (d == 0) ? q0.size() : q1.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bitq_t ascii;
      bitq_t f1;
      bitq_t f2;
      int    lens[4] = '{1, 479, 480, 481};
      int    n;
      int    k;
      logic [7:0] ch;

      for (int i = 0; i < 2; i++) begin
         fk[i] = 32; pos[i] = 0; fsp[i] = 0; lsp[i] = 0; rc[i] = '0; fw[i] = '0;
      end

      // Reset with a start bit presented throughout.
      drv_sel = 2; drv_valid = 1'b1; drv_sof = 1'b1; drv_dat = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0; drv_valid = 1'b0; drv_sof = 1'b0;
      @(negedge clk);
      chk("reset_state0", {bus0.in_ready, bus0.out_valid, bus0.data_out, bus0.out_sof,
                           bus0.out_fcs_start, bus0.out_last}, 6'b100000);
      chk("reset_state1", {bus1.in_ready, bus1.out_valid, bus1.data_out, bus1.out_sof,
                           bus1.out_fcs_start, bus1.out_last}, 6'b100000);
      repeat (5) @(negedge clk);

      // Known vector "123456789", LSB first.
      for (int b = 0; b < 9; b++) begin
         ch = 8'h31 + 8'(b);
         for (int j = 0; j < 8; j++) ascii.push_back(ch[j]);
      end
      push_frame(0, 0, ascii);
      drive(0, ascii, 0);
      wait_done(0);
      chk("kv_fcs", fw[0], 32'hCBF43926);
      chk("kv_fcs_start_pos", fsp[0], 73);
      chk("kv_last_pos", lsp[0], 104);

      // Padding of an 8-bit payload.
      f1 = rand_bits(8);
      push_frame(1, 480, f1);
      drive(1, f1, 0);
      n = 0;
      while (!rdy(1) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("pad_ready_low_cycles", n, 504);
      wait_done(1);
      chk("pad_frame_len", lsp[1], 512);

      // Gapped known vector.
      push_frame(0, 0, ascii);
      drive(0, ascii, 50);
      wait_done(0);
      chk("gap_kv_fcs", fw[0], 32'hCBF43926);

      // Back-to-back frames.
      f1 = rand_bits(40);
      f2 = rand_bits(64);
      push_frame(0, 0, f1);
      push_frame(0, 0, f2);
      fork
         begin
            drive(0, f1, 0);
            drive(0, f2, 0);
         end
         begin
            int m = 0;
            @(negedge clk);
            while (!bus0.out_last && m < 3000) begin
               @(negedge clk);
               m++;
            end
            chk("b2b_last_seen", m < 3000, 1'b1);
            @(negedge clk);
            chk("b2b_sof_after_last", bus0.out_sof, 1'b1);
         end
      join
      wait_done(0);
      chk("b2b_len", lsp[0], 96);

      // Length boundaries around the minimum frame size, and single-bit frames.
      foreach (lens[i]) begin
         f1 = rand_bits(lens[i]);
         push_frame(1, 480, f1);
         drive(1, f1, 0);
         wait_done(1);
         chk("bound_len", lsp[1], ((lens[i] > 480) ? lens[i] : 480) + 32);
      end
      f1 = rand_bits(1);
      push_frame(0, 0, f1);
      drive(0, f1, 0);
      wait_done(0);
      chk("single_bit_fcs_pos", fsp[0], 2);
      chk("single_bit_len", lsp[0], 33);

      // Reset after 10 FCS bits, then a clean frame.
      f1 = rand_bits(72);
      push_frame(0, 0, f1);
      drive(0, f1, 0);
      n = 0; k = 0;
      while (k < 10 && n < 500) begin
         @(negedge clk);
         #1;
         if (bus0.out_fcs_start)             k = 1;
         else if (k > 0 && bus0.out_valid)   k++;
         n++;
      end
      chk("fcs_bits_before_reset", k, 10);
      reset = 1'b1;
      q0.delete();
      @(negedge clk);
      chk("reset_mid_fcs_valid", bus0.out_valid, 1'b0);
      #1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      f1 = rand_bits(72);
      push_frame(0, 0, f1);
      drive(0, f1, 30);
      wait_done(0);
      chk("post_reset_len", lsp[0], 104);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
